// File: rtl/sync_updown_ctr_pkg.sv
// Shared constants for the synchronous up/down counter: mode and direction encodings.
package sync_updown_ctr_pkg;

  localparam logic ModeWrap = 1'b0;
  localparam logic ModeSat  = 1'b1;
  localparam logic DirDown  = 1'b0;
  localparam logic DirUp    = 1'b1;

endpackage

// File: rtl/sync_updown_ctr_dff.sv
// One-bit D flip-flop with synchronous active-low clear, enable and a configurable clear value.
module dff_en_sclr #(
  parameter bit ClrVal = 1'b0
) (
  input  logic clk_i,
  input  logic clear_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      q_q <= ClrVal;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sync_updown_ctr.sv
// Parametrised synchronous up/down counter with load, programmable modulus, wrap/saturate
// modes, a combinational terminal-count flag and a registered carry/borrow pulse.
module sync_updown_ctr
  import sync_updown_ctr_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVec = WIDTH'(RESET_VAL);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("sync_updown_ctr: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_ctr: MODULUS out of range");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("sync_updown_ctr: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] q_d;
  logic             co_d;
  logic             at_max;
  logic             at_min;
  logic             q_en;

  assign at_max = (q == MaxVal);
  assign at_min = (q == '0);
  // Stages only need to move on load or count; hold keeps the flops idle.
  assign q_en   = load | en;

  always_comb begin
    q_d  = q;
    co_d = 1'b0;
    if (load) begin
      // With a full-range modulus MaxVal is all ones, so the clamp never triggers.
      q_d = (d > MaxVal) ? MaxVal : d;
    end else if (en) begin
      if (up == DirUp) begin
        if (!at_max) begin
          q_d = q + WIDTH'(1);
        end else if (mode == ModeWrap) begin
          q_d  = '0;
          co_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          q_d = q - WIDTH'(1);
        end else if (mode == ModeWrap) begin
          q_d  = MaxVal;
          co_d = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_q_stage
    dff_en_sclr #(
      .ClrVal(RstVec[i])
    ) u_q_dff (
      .clk_i   (clk),
      .clear_ni(clear_n),
      .en_i    (q_en),
      .d_i     (q_d[i]),
      .q_o     (q[i])
    );
  end

  dff_en_sclr #(
    .ClrVal(1'b0)
  ) u_co_dff (
    .clk_i   (clk),
    .clear_ni(clear_n),
    .en_i    (1'b1),
    .d_i     (co_d),
    .q_o     (co)
  );

  assign tc = en & ~load & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_sync_updown_ctr.sv
// Scoreboard bench: two counter instances (mod 10 and full-range mod 16) share one stimulus
// stream; a reference model queues expected q/co per edge and a monitor compares them.
module tb_sync_updown_ctr;

  localparam int unsigned MA = 10;
  localparam int unsigned RA = 0;
  localparam int unsigned MB = 16;
  localparam int unsigned RB = 3;

  logic       clk;
  logic       clear_n;
  logic       en;
  logic       up;
  logic       mode;
  logic       load;
  logic [3:0] d;
  logic [3:0] q_a;
  logic [3:0] q_b;
  logic       tc_a;
  logic       tc_b;
  logic       co_a;
  logic       co_b;

  typedef struct {
    int qa;
    bit coa;
    int qb;
    bit cob;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   co_pulses = 0;
  bit   known     = 0;
  int   mqa;
  int   mqb;

  sync_updown_ctr #(
    .WIDTH    (4),
    .MODULUS  (MA),
    .RESET_VAL(RA)
  ) u_dut_a (
    .clk    (clk),
    .clear_n(clear_n),
    .en     (en),
    .up     (up),
    .mode   (mode),
    .load   (load),
    .d      (d),
    .q      (q_a),
    .tc     (tc_a),
    .co     (co_a)
  );

  sync_updown_ctr #(
    .WIDTH    (4),
    .MODULUS  (MB),
    .RESET_VAL(RB)
  ) u_dut_b (
    .clk    (clk),
    .clear_n(clear_n),
    .en     (en),
    .up     (up),
    .mode   (mode),
    .load   (load),
    .d      (d),
    .q      (q_b),
    .tc     (tc_b),
    .co     (co_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour in plain modular arithmetic on integers.
  function automatic void model(input int qc, input int m, input int rst, input bit c,
                                input bit l, input bit e, input bit u, input bit md,
                                input int dv, output int qn, output bit con);
    qn  = qc;
    con = 1'b0;
    if (!c) begin
      qn = rst;
    end else if (l) begin
      qn = (dv < m) ? dv : m - 1;
    end else if (e) begin
      if (u) begin
        if (md == 1'b0) begin
          qn  = (qc + 1) % m;
          con = (qc + 1 == m);
        end else begin
          qn = (qc + 1 < m) ? qc + 1 : qc;
        end
      end else begin
        if (md == 1'b0) begin
          qn  = (qc + m - 1) % m;
          con = (qc == 0);
        end else begin
          qn = (qc > 0) ? qc - 1 : 0;
        end
      end
    end
  endfunction

  function automatic bit model_tc(input int qc, input int m, input bit l, input bit e,
                                  input bit u);
    return e && !l && (u ? (qc == m - 1) : (qc == 0));
  endfunction

  // Entered on a falling edge; drives one cycle of inputs and queues the edge's outcome.
  task automatic step(input bit c, input bit l, input bit e, input bit u, input bit md,
                      input int dv);
    exp_t x;
    clear_n = c;
    load    = l;
    en      = e;
    up      = u;
    mode    = md;
    d       = 4'(dv);
    #1;
    if (known) begin
      chk("tc_a", {31'b0, tc_a}, {31'b0, model_tc(mqa, MA, l, e, u)});
      chk("tc_b", {31'b0, tc_b}, {31'b0, model_tc(mqb, MB, l, e, u)});
    end
    if (known || !c) begin
      model(mqa, MA, RA, c, l, e, u, md, dv, x.qa, x.coa);
      model(mqb, MB, RB, c, l, e, u, md, dv, x.qb, x.cob);
      mqa   = x.qa;
      mqb   = x.qb;
      known = 1'b1;
      sb.push_back(x);
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_a", {28'b0, q_a}, e.qa);
      chk("co_a", {31'b0, co_a}, {31'b0, e.coa});
      chk("q_b", {28'b0, q_b}, e.qb);
      chk("co_b", {31'b0, co_b}, {31'b0, e.cob});
      if (co_a === 1'b1) co_pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    clear_n = 1'b1;
    load    = 1'b0;
    en      = 1'b0;
    up      = 1'b0;
    mode    = 1'b0;
    d       = '0;
    @(negedge clk);

    // Clear dominates load and enable, then count up from reset.
    step(0, 1, 1, 1, 0, 7);
    step(0, 1, 1, 1, 0, 7);
    chk("reset_q_a", {28'b0, q_a}, RA);
    chk("reset_q_b", {28'b0, q_b}, RB);
    repeat (3) step(1, 0, 1, 1, 0, 0);
    chk("count_q_a", {28'b0, q_a}, 3);

    // Continuous wrap up: two carry pulses in 25 edges.
    step(0, 0, 0, 0, 0, 0);
    mark = co_pulses;
    repeat (25) step(1, 0, 1, 1, 0, 0);
    chk("co_pulses", co_pulses - mark, 2);

    // Wrap down, then saturate at zero.
    step(1, 1, 0, 0, 0, 2);
    repeat (3) step(1, 0, 1, 0, 0, 0);
    chk("wrap_down_q_a", {28'b0, q_a}, 9);
    step(1, 1, 0, 0, 1, 1);
    repeat (3) step(1, 0, 1, 0, 1, 0);
    chk("sat_down_q_a", {28'b0, q_a}, 0);

    // Load clamp, then load beating a wrap on the same edge.
    step(1, 1, 1, 0, 0, 13);
    step(1, 1, 1, 1, 0, 5);
    chk("load_prio_q_a", {28'b0, q_a}, 5);

    // Clear on what would be a wrap edge.
    step(1, 1, 0, 0, 0, 9);
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);

    // Full-range instance wraps 15 -> 0; then hold.
    repeat (20) step(1, 0, 1, 1, 0, 0);
    repeat (5) step(1, 0, 0, 1, 0, 0);

    // Randomised traffic.
    repeat (400) begin
      step(bit'($urandom_range(0, 19) != 0), bit'($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
    end

    step(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
